mips32_fetch_queue: RTL and testbench

//  Instruction fetch front-end for the MIPS32 pipeline. Drives the synchronous

---
 rtl/mips32_fetch_queue.sv | 135 +++++++++++++
 tb/tb_mips32_fetch_queue.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction-fetch front end: drives a synchronous instruction memory and
// queues {IR, NPC} for IF/ID. Optional FQ_STATS_EN adds fetch/flush statistics ports.
module mips32_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              halt,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_ir,
  output logic [31:0]       out_npc,
  output logic              fq_busy,
  output logic [1:0]        state_dbg
`ifdef FQ_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_flushed
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_HALTED = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [31:0]     pc;
  logic [31:0]     issued_npc;
  logic [CW-1:0]   count;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            inflight;
  logic            drop;
  logic [31:0]     ir_mem  [DEPTH];
  logic [31:0]     npc_mem [DEPTH];

  logic            flush, issue, push, pop;
  logic [CW:0]     occ;

  // Handshake: an entry transfers on a rising edge where out_valid && out_ready;
  // out_valid never depends on out_ready and the head stays put until accepted.
  assign occ       = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign flush     = (state == S_FETCH) && (halt || redirect);
  assign issue     = (state == S_FETCH) && !halt && !redirect && (occ < DEPTH_C);
  assign push      = inflight && !drop && !flush;
  assign out_valid = (count != '0);
  assign pop       = (state == S_FETCH) && !flush && out_valid && out_ready;

  assign imem_req  = issue;
  assign imem_addr = pc[ADDR_W-1:0];
  assign out_ir    = out_valid ? ir_mem[rd_ptr]  : 32'h0;
  assign out_npc   = out_valid ? npc_mem[rd_ptr] : 32'h0;
  assign fq_busy   = (state == S_FETCH);
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (fetch_en) state_nxt = S_FETCH;
      S_FETCH:  if (halt)     state_nxt = S_HALTED;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      issued_npc <= 32'h0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      inflight   <= 1'b0;
      drop       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        // The response sitting on imem_rdata this cycle is discarded with the queue.
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        inflight <= 1'b0;
        drop     <= inflight;
        if (!halt) pc <= redirect_pc;
      end else begin
        inflight <= issue;
        drop     <= 1'b0;
        if (issue) begin
          pc         <= pc + 32'd1;
          issued_npc <= pc + 32'd1;
        end
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (push) begin
      ir_mem[wr_ptr]  <= imem_rdata;
      npc_mem[wr_ptr] <= issued_npc;
    end
  end

`ifdef FQ_STATS_EN
  logic [32:0] flushed_sum;
  assign flushed_sum = {1'b0, stat_flushed} + 33'(count) + 33'(inflight);

  always_ff @(posedge clk1) begin
    if (rst) begin
      stat_fetched <= 32'h0;
      stat_flushed <= 32'h0;
    end else begin
      if (push && (stat_fetched != 32'hFFFF_FFFF)) stat_fetched <= stat_fetched + 32'd1;
      if (flush) stat_flushed <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Directed bench for mips32_fetch_queue: a main instance at RESET_PC=0 and a
// second instance at RESET_PC=1022 for address wrap; optional FQ_STATS_EN ports.
module tb_mips32_fetch_queue;

  logic        clk1 = 1'b0;
  logic        rst, fetch_en, halt, redirect, out_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, out_valid, fq_busy;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata, out_ir, out_npc;
  logic [1:0]  state_dbg;

  logic        w_fetch_en, w_ready;
  logic        w_req, w_valid, w_busy;
  logic [9:0]  w_addr;
  logic [31:0] w_rdata, w_ir, w_npc;
  logic [1:0]  w_state;
`ifdef FQ_STATS_EN
  logic [31:0] stat_fetched, stat_flushed, w_fetched, w_flushed;
`endif

  logic [31:0] mem [1024];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk1 = ~clk1;

  mips32_fetch_queue #(.DEPTH(4), .ADDR_W(10), .RESET_PC(32'h0)) u_dut (
    .clk1(clk1), .rst(rst), .fetch_en(fetch_en), .halt(halt), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir), .out_npc(out_npc), .fq_busy(fq_busy), .state_dbg(state_dbg)
`ifdef FQ_STATS_EN
    , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
  );

  mips32_fetch_queue #(.DEPTH(4), .ADDR_W(10), .RESET_PC(32'd1022)) u_wrap (
    .clk1(clk1), .rst(rst), .fetch_en(w_fetch_en), .halt(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .out_valid(w_valid), .out_ready(w_ready),
    .out_ir(w_ir), .out_npc(w_npc), .fq_busy(w_busy), .state_dbg(w_state)
`ifdef FQ_STATS_EN
    , .stat_fetched(w_fetched), .stat_flushed(w_flushed)
`endif
  );

  // Synchronous instruction memories; garbage when no read so stray pushes show up.
  always @(posedge clk1) imem_rdata <= imem_req ? mem[imem_addr] : 32'hDEAD_BEEF;
  always @(posedge clk1) w_rdata    <= w_req    ? mem[w_addr]    : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk1);
    #2;
  endtask

  // Pop n words with out_ready=1, expecting mem[first..] and npc first+1.. in order.
  task automatic drain(input int n, input int first);
    int got = 0;
    int idx = first;
    out_ready = 1'b1;
    for (int t = 0; t < 200 && got < n; t++) begin
      #1;
      if (out_valid) begin
        chk("drain_ir", out_ir, mem[idx[9:0]]);
        chk("drain_npc", out_npc, 32'(idx + 1));
        idx++;
        got++;
      end
      cyc();
    end
    if (got < n) chk("drain_timeout", 32'(got), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq;
    int nval;
    int found;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_0000 + 32'(i);
    rst = 1'b1; fetch_en = 1'b0; halt = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; out_ready = 1'b0; w_fetch_en = 1'b0; w_ready = 1'b1;

    // T1 reset and first-word latency
    cyc(); cyc();
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_ir", out_ir, 32'h0);
    chk("rst_npc", out_npc, 32'h0);
    chk("rst_busy", {31'b0, fq_busy}, 32'h0);
    chk("rst_state", {30'b0, state_dbg}, 32'h0);
    chk("rst_w_valid", {31'b0, w_valid}, 32'h0);
    rst = 1'b0;
    fetch_en = 1'b1;
    cyc();
    fetch_en = 1'b0;
    #1;
    chk("c1_busy", {31'b0, fq_busy}, 32'h1);
    chk("c1_req", {31'b0, imem_req}, 32'h1);
    chk("c1_addr", {22'b0, imem_addr}, 32'h0);
    cyc(); #1;
    chk("c2_req", {31'b0, imem_req}, 32'h1);
    chk("c2_addr", {22'b0, imem_addr}, 32'h1);
    chk("c2_valid", {31'b0, out_valid}, 32'h0);
    cyc(); #1;
    chk("c3_valid", {31'b0, out_valid}, 32'h1);
    chk("c3_ir", out_ir, mem[0]);
    chk("c3_npc", out_npc, 32'h1);

    // T2 backpressure: only DEPTH reads in total, head held stable
    nreq = 2;
    for (int t = 0; t < 12; t++) begin
      #1;
      if (imem_req) nreq++;
      cyc();
    end
    chk("full_req_count", 32'(nreq), 32'd4);
    #1;
    chk("hold_valid", {31'b0, out_valid}, 32'h1);
    chk("hold_ir", out_ir, mem[0]);
    drain(10, 0);

    // T3 redirect with a read in flight
    found = 0;
    for (int t = 0; t < 20 && found == 0; t++) begin
      #1;
      if (imem_req) found = 1; else cyc();
    end
    chk("req_seen", 32'(found), 32'd1);
    cyc();
    redirect = 1'b1; redirect_pc = 32'h20;
    #1;
    chk("redir_no_req", {31'b0, imem_req}, 32'h0);
    cyc();
    redirect = 1'b0;
    #1;
    chk("redir_req", {31'b0, imem_req}, 32'h1);
    chk("redir_addr", {22'b0, imem_addr}, 32'h20);
    chk("redir_valid0", {31'b0, out_valid}, 32'h0);
    cyc(); #1;
    chk("redir_valid1", {31'b0, out_valid}, 32'h0);
    cyc(); #1;
    chk("redir_valid2", {31'b0, out_valid}, 32'h1);
    chk("redir_ir", out_ir, mem[32'h20]);
    chk("redir_npc", out_npc, 32'h21);
    drain(4, 32'h20);

    // Back-to-back redirects: the last one wins
    redirect = 1'b1; redirect_pc = 32'h40;
    cyc();
    redirect_pc = 32'h80;
    cyc();
    redirect = 1'b0;
    #1;
    chk("b2b_addr", {22'b0, imem_addr}, 32'h80);
    drain(3, 32'h80);

    // T4 halt and redirect together: halted for good
    halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
    #1;
    chk("halt_no_req", {31'b0, imem_req}, 32'h0);
    cyc();
    halt = 1'b0;
    #1;
    chk("halt_busy", {31'b0, fq_busy}, 32'h0);
    chk("halt_state", {30'b0, state_dbg}, 32'h2);
    chk("halt_valid", {31'b0, out_valid}, 32'h0);
    nreq = 0; nval = 0;
    fetch_en = 1'b1; out_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      redirect = t[0];
      #1;
      if (imem_req) nreq++;
      if (out_valid) nval++;
      cyc();
    end
    redirect = 1'b0; fetch_en = 1'b0;
    chk("halt_req_count", 32'(nreq), 32'd0);
    chk("halt_valid_count", 32'(nval), 32'd0);

    // T6: 4 pushes, pop 1, redirect with 3 queued + 1 in flight
    rst = 1'b1; out_ready = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    chk("rst2_state", {30'b0, state_dbg}, 32'h0);
`ifdef FQ_STATS_EN
    chk("rst2_fetched", stat_fetched, 32'h0);
    chk("rst2_flushed", stat_flushed, 32'h0);
`endif
    fetch_en = 1'b1;
    cyc();
    fetch_en = 1'b0;
    for (int t = 0; t < 7; t++) cyc();
    out_ready = 1'b1;
    #1;
    chk("st_full_valid", {31'b0, out_valid}, 32'h1);
    chk("st_full_ir", out_ir, mem[0]);
    chk("st_full_no_req", {31'b0, imem_req}, 32'h0);
    cyc();
    out_ready = 1'b0;
    #1;
    chk("st_refill_req", {31'b0, imem_req}, 32'h1);
    chk("st_refill_addr", {22'b0, imem_addr}, 32'h4);
    chk("st_head", out_ir, mem[1]);
    cyc(); #1;
    chk("st_reserved", {31'b0, imem_req}, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    #1;
`ifdef FQ_STATS_EN
    chk("st_fetched", stat_fetched, 32'd4);
    chk("st_flushed", stat_flushed, 32'd4);
`endif
    chk("st_flush_valid", {31'b0, out_valid}, 32'h0);
    chk("st_flush_addr", {22'b0, imem_addr}, 32'h100);
    drain(2, 32'h100);

    // T5 wrap from RESET_PC=1022
    w_fetch_en = 1'b1;
    cyc();
    w_fetch_en = 1'b0;
    #1;
    chk("wrap_addr0", {22'b0, w_addr}, 32'd1022);
    cyc(); #1;
    chk("wrap_addr1", {22'b0, w_addr}, 32'd1023);
    cyc(); #1;
    chk("wrap_addr2", {22'b0, w_addr}, 32'd0);
    chk("wrap_ir0", w_ir, mem[1022]);
    chk("wrap_npc0", w_npc, 32'd1023);
    cyc(); #1;
    chk("wrap_ir1", w_ir, mem[1023]);
    chk("wrap_npc1", w_npc, 32'd1024);
    cyc(); #1;
    chk("wrap_ir2", w_ir, mem[0]);
    chk("wrap_npc2", w_npc, 32'd1025);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
